prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Serial program/data loader inside the tiny processor.
- Receives 13-bit frames on mosi_in from the FPGA-demo driver. The frame type is selected by mode_in.
- Deserialises each frame and writes the payload byte into a 16x8 instruction memory or a 16x8 data memory.
- Gates core execution (run_out) and reports completion back to the driver (done_out).
- The core reads imem/dmem through this block's read ports.

Parameters:
- FRAME_BITS, 13: bits per frame. Layout, LSB first: addr[3:0], byte[7:0], stop bit (must be 0).
- BIT_CYCLES, 2: clk cycles each bit is held on mosi_in.
- LEAD_CYCLES, 2: clk cycles of mode_in≠00 before bit 0 starts.
- DEPTH, 16: entries per memory; address width is 4.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- mosi_in  in  1  serial data, LSB first
- mode_in  in  2  00 idle, 01 load imem, 10 load dmem, 11 run
- imem_raddr  in  4  core instruction fetch address
- imem_rdata  out  8  combinational read of imem
- dmem_raddr  in  4  core data read address
- dmem_rdata  out  8  combinational read of dmem
- dmem_we  in  1  core data write enable
- dmem_waddr  in  4  core write address
- dmem_wdata  in  8  core write data
- halt_in  in  1  core finished
- run_out  out  1  core may execute
- done_out  out  1  run completed, to driver done_in
- frame_err_out  out  1  sticky frame error
- frames_rcvd  out  5  committed frames since last IDLE→load start
- checksum_out  out  8  see Optional Feature

Behaviour:
- Reset is synchronous, active-high (rst), on clock clk.
- Reset values: run_out=0, done_out=0, frame_err_out=0, frames_rcvd=0, checksum_out=0, FSM=IDLE, all counters 0.
- Memory contents are not reset.
- States: IDLE, LEAD, SHIFT, COMMIT, GAP, RUN, HALT.
- IDLE:
  - mode_in 01 or 10 → LEAD; latch target (imem/dmem) from mode_in.
  - If the previous state was RUN or HALT, also clear frames_rcvd.
  - mode_in 11 → RUN.
- LEAD:
  - Count LEAD_CYCLES cycles, including the entry cycle, then → SHIFT.
  - mode_in≠latched mode → abort to IDLE, set frame_err_out.
- SHIFT:
  - Bit-phase counter runs 0..BIT_CYCLES-1.
  - Sample mosi_in when phase==BIT_CYCLES-1. Insert at the MSB of a 13-bit shift register and shift right.
  - After the FRAME_BITS-th sample → COMMIT.
  - mode_in changes to a different non-00 value → abort, set frame_err_out.
  - mode_in==00 before all bits are received → abort, set frame_err_out.
- COMMIT (one cycle):
  - If sr[12]==0: write sr[11:4] to target[sr[3:0]] and increment frames_rcvd.
  - frames_rcvd saturates at 31.
  - If sr[12]==1: no write, set frame_err_out.
  - Always → GAP.
- GAP: mode_in==00 → IDLE; mode_in==11 → RUN; otherwise stay in GAP.
  - The same mode held after a frame never starts a new frame; a new frame needs a pass through 00.
- RUN:
  - run_out=1.
  - Core dmem writes take effect on the clock edge when dmem_we=1. Outside RUN, dmem_we is ignored.
  - halt_in=1 → HALT (run_out falls the next cycle).
  - mode_in==00 → IDLE.
- HALT:
  - done_out=1, run_out=0.
  - Stay until mode_in==00, then → IDLE with done_out=0 the next cycle.
- Reads are combinational and reflect a write on the cycle after it.
- frame_err_out clears only on rst or on entry to LEAD from IDLE when frames_rcvd==0.
- Reset mid-frame: discard partial shift, return to IDLE. Already-written memory is preserved.
- mode_in==11 in LEAD or SHIFT → abort, set frame_err_out, → RUN.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- With the macro: checksum_out is the running XOR of every byte committed to imem or dmem since the last clear. It clears together with frames_rcvd. An imem commit and a dmem commit both fold in.
- Without the macro: checksum_out is tied to 0 and no checksum register is synthesised.

Test Plan:
- Reset, then send imem frame addr=3, byte=0xA5 (mosi bits 1,1,0,0,1,0,1,0,0,1,0,1,0, each held 2 cycles after 2 lead cycles) → imem[3]=0xA5, frames_rcvd=1, frame_err_out=0.
- Load 16 imem frames then 16 dmem frames (byte=addr*0x11), then mode 11 → frames_rcvd=31 (saturated), run_out=1 one cycle after mode 11. Every imem/dmem entry reads back as expected.
- Frame with stop bit=1 → no memory change, frame_err_out=1, FSM waits in GAP until mode 00.
- mode_in drops to 00 after 6 bits → frame aborted, memory unchanged, frame_err_out=1.
- RUN with core writing dmem[5]=0x3C, then halt_in=1 → dmem[5]=0x3C, run_out=0 and done_out=1 next cycle. mode 00 → done_out=0 next cycle.
- With PROG_LOADER_CHECKSUM_EN, commit bytes 0x0F, 0xF0, 0x33 → checksum_out=0xCC. Without the macro → checksum_out=0.

Source files
------------

// File: rtl/prog_loader.sv
// Serial program/data loader: deserialises 13-bit frames into a 16x8 imem or dmem,
// then gates core execution. Optional running checksum under PROG_LOADER_CHECKSUM_EN.
//
// state  | meaning
// IDLE   | waiting for a load mode or run request
// LEAD   | lead-in before bit 0 (the IDLE cycle that saw the mode is the first lead cycle)
// SHIFT  | sampling frame bits, one per BIT_CYCLES clocks
// COMMIT | write payload if the stop bit is clean
// GAP    | frame done; needs mode 00 (or 11) before anything else
// RUN    | core executing
// HALT   | core finished, done_out raised until mode 00
module prog_loader #(
  parameter int FRAME_BITS  = 13,
  parameter int BIT_CYCLES  = 2,
  parameter int LEAD_CYCLES = 2,
  parameter int DEPTH       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mosi_in,
  input  logic [1:0] mode_in,
  input  logic [3:0] imem_raddr,
  output logic [7:0] imem_rdata,
  input  logic [3:0] dmem_raddr,
  output logic [7:0] dmem_rdata,
  input  logic       dmem_we,
  input  logic [3:0] dmem_waddr,
  input  logic [7:0] dmem_wdata,
  input  logic       halt_in,
  output logic       run_out,
  output logic       done_out,
  output logic       frame_err_out,
  output logic [4:0] frames_rcvd,
  output logic [7:0] checksum_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BW = $clog2(FRAME_BITS);
  localparam int LW = (LEAD_CYCLES > 2) ? $clog2(LEAD_CYCLES - 1) : 1;

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_IMEM = 2'b01;
  localparam logic [1:0] MODE_DMEM = 2'b10;
  localparam logic [1:0] MODE_RUN  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_SHIFT,
    S_COMMIT,
    S_GAP,
    S_RUN,
    S_HALT
  } state_t;

  state_t                  state;
  logic [1:0]              tgt_mode;
  logic [LW-1:0]           lead_cnt;
  logic [PW-1:0]           phase;
  logic [BW-1:0]           bits_left;
  logic [FRAME_BITS-1:0]   sr;
  logic                    prev_run;

  logic [7:0]              imem [DEPTH];
  logic [7:0]              dmem [DEPTH];

  logic                    load_req;
  logic                    clr_cnt;
  logic                    commit_ok;
  logic [AW-1:0]           commit_addr;
  logic [7:0]              commit_byte;

  assign load_req    = (mode_in == MODE_IMEM) || (mode_in == MODE_DMEM);
  assign clr_cnt     = (state == S_IDLE) && load_req && prev_run;
  assign commit_ok   = (state == S_COMMIT) && !sr[FRAME_BITS-1];
  assign commit_addr = sr[AW-1:0];
  assign commit_byte = sr[AW+7:AW];

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      tgt_mode      <= MODE_IDLE;
      lead_cnt      <= '0;
      phase         <= '0;
      bits_left     <= '0;
      sr            <= '0;
      prev_run      <= 1'b0;
      run_out       <= 1'b0;
      done_out      <= 1'b0;
      frame_err_out <= 1'b0;
      frames_rcvd   <= '0;
    end else begin
      prev_run <= (state == S_RUN) || (state == S_HALT);
      case (state)
        S_IDLE: begin
          run_out  <= 1'b0;
          done_out <= 1'b0;
          if (load_req) begin
            state    <= S_LEAD;
            tgt_mode <= mode_in;
            lead_cnt <= LW'(LEAD_CYCLES - 2);
            if (clr_cnt) frames_rcvd <= '0;
            // error clears only when this load starts from an empty count
            if (clr_cnt || (frames_rcvd == '0)) frame_err_out <= 1'b0;
          end else if (mode_in == MODE_RUN) begin
            state   <= S_RUN;
            run_out <= 1'b1;
          end
        end

        S_LEAD: begin
          if (mode_in != tgt_mode) begin
            frame_err_out <= 1'b1;
            state         <= (mode_in == MODE_RUN) ? S_RUN : S_IDLE;
            run_out       <= (mode_in == MODE_RUN);
          end else if (lead_cnt == '0) begin
            state     <= S_SHIFT;
            phase     <= '0;
            bits_left <= BW'(FRAME_BITS - 1);
          end else begin
            lead_cnt <= lead_cnt - 1'b1;
          end
        end

        S_SHIFT: begin
          if (mode_in != tgt_mode) begin
            frame_err_out <= 1'b1;
            state         <= (mode_in == MODE_RUN) ? S_RUN : S_IDLE;
            run_out       <= (mode_in == MODE_RUN);
          end else if (phase == PW'(BIT_CYCLES - 1)) begin
            phase <= '0;
            sr    <= {mosi_in, sr[FRAME_BITS-1:1]};
            if (bits_left == '0) state <= S_COMMIT;
            else                 bits_left <= bits_left - 1'b1;
          end else begin
            phase <= phase + 1'b1;
          end
        end

        S_COMMIT: begin
          if (!sr[FRAME_BITS-1]) begin
            if (frames_rcvd != 5'd31) frames_rcvd <= frames_rcvd + 5'd1;
          end else begin
            frame_err_out <= 1'b1;
          end
          state <= S_GAP;
        end

        S_GAP: begin
          if (mode_in == MODE_IDLE) begin
            state <= S_IDLE;
          end else if (mode_in == MODE_RUN) begin
            state   <= S_RUN;
            run_out <= 1'b1;
          end
        end

        S_RUN: begin
          if (mode_in == MODE_IDLE) begin
            state   <= S_IDLE;
            run_out <= 1'b0;
          end else if (halt_in) begin
            state    <= S_HALT;
            run_out  <= 1'b0;
            done_out <= 1'b1;
          end
        end

        S_HALT: begin
          if (mode_in == MODE_IDLE) begin
            state    <= S_IDLE;
            done_out <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // Memories are deliberately left out of reset so a reset keeps a loaded program.
  always_ff @(posedge clk) begin
    if (commit_ok && (tgt_mode == MODE_IMEM)) imem[commit_addr] <= commit_byte;
  end

  always_ff @(posedge clk) begin
    if (commit_ok && (tgt_mode == MODE_DMEM))  dmem[commit_addr] <= commit_byte;
    else if ((state == S_RUN) && dmem_we)      dmem[dmem_waddr]  <= dmem_wdata;
  end

  assign imem_rdata = imem[imem_raddr];
  assign dmem_rdata = dmem[dmem_raddr];

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk) begin
    if (rst || clr_cnt) csum <= 8'h00;
    else if (commit_ok) csum <= csum ^ commit_byte;
  end

  assign checksum_out = csum;
`else
  assign checksum_out = 8'h00;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader; expected checksum follows PROG_LOADER_CHECKSUM_EN.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       mosi_in;
  logic [1:0] mode_in;
  logic [3:0] imem_raddr;
  logic [7:0] imem_rdata;
  logic [3:0] dmem_raddr;
  logic [7:0] dmem_rdata;
  logic       dmem_we;
  logic [3:0] dmem_waddr;
  logic [7:0] dmem_wdata;
  logic       halt_in;
  logic       run_out;
  logic       done_out;
  logic       frame_err_out;
  logic [4:0] frames_rcvd;
  logic [7:0] checksum_out;

  int errors = 0;
  int checks = 0;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  prog_loader dut (
    .clk(clk), .rst(rst), .mosi_in(mosi_in), .mode_in(mode_in),
    .imem_raddr(imem_raddr), .imem_rdata(imem_rdata),
    .dmem_raddr(dmem_raddr), .dmem_rdata(dmem_rdata),
    .dmem_we(dmem_we), .dmem_waddr(dmem_waddr), .dmem_wdata(dmem_wdata),
    .halt_in(halt_in), .run_out(run_out), .done_out(done_out),
    .frame_err_out(frame_err_out), .frames_rcvd(frames_rcvd),
    .checksum_out(checksum_out)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] mk_frame(input logic stop, input logic [7:0] b,
                                           input logic [3:0] a);
    return {stop, b, a};
  endfunction

  // Called #1 after an edge with the DUT idle; returns #1 after the last sampling edge.
  task automatic shift_bits(input logic [1:0] m, input logic [12:0] f, input int n);
    mode_in = m;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) begin
      mosi_in = f[i];
      repeat (2) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [1:0] m, input logic [3:0] a, input logic [7:0] b);
    shift_bits(m, mk_frame(1'b0, b, a), 13);
    @(posedge clk); #1;
    mode_in = 2'b00;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; mosi_in = 1'b0; mode_in = 2'b00; imem_raddr = '0; dmem_raddr = '0;
    dmem_we = 1'b0; dmem_waddr = '0; dmem_wdata = '0; halt_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (run_out !== 1'b0) begin errors++; $display("FAIL reset_run: got %b exp 0", run_out); end
    checks++; if (done_out !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", done_out); end
    checks++; if (frame_err_out !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", frame_err_out); end
    checks++; if (frames_rcvd !== 5'd0) begin errors++; $display("FAIL reset_frames: got %0d exp 0", frames_rcvd); end
    checks++; if (checksum_out !== 8'h00) begin errors++; $display("FAIL reset_cksum: got %h exp 00", checksum_out); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_frame;
    send_frame(2'b01, 4'd3, 8'hA5);
    imem_raddr = 4'd3; #1;
    checks++; if (imem_rdata !== 8'hA5) begin errors++; $display("FAIL single_imem3: got %h exp a5", imem_rdata); end
    checks++; if (frames_rcvd !== 5'd1) begin errors++; $display("FAIL single_frames: got %0d exp 1", frames_rcvd); end
    checks++; if (frame_err_out !== 1'b0) begin errors++; $display("FAIL single_err: got %b exp 0", frame_err_out); end
    checks++; if (checksum_out !== (CK ? 8'hA5 : 8'h00)) begin errors++; $display("FAIL single_cksum: got %h", checksum_out); end
  endtask

  task automatic test_full_load;
    logic [7:0] exp_b;
    for (int a = 0; a < 16; a++) send_frame(2'b01, 4'(a), 8'(a * 8'h11));
    checks++; if (frames_rcvd !== 5'd17) begin errors++; $display("FAIL full_frames17: got %0d exp 17", frames_rcvd); end
    for (int a = 0; a < 16; a++) send_frame(2'b10, 4'(a), 8'(a * 8'h11));
    checks++; if (frames_rcvd !== 5'd31) begin errors++; $display("FAIL full_frames_sat: got %0d exp 31", frames_rcvd); end
    checks++; if (checksum_out !== (CK ? 8'hA5 : 8'h00)) begin errors++; $display("FAIL full_cksum: got %h", checksum_out); end
    mode_in = 2'b11;
    @(posedge clk); #1;
    checks++; if (run_out !== 1'b1) begin errors++; $display("FAIL full_run: got %b exp 1", run_out); end
    for (int a = 0; a < 16; a++) begin
      imem_raddr = 4'(a); dmem_raddr = 4'(a); exp_b = 8'(a * 8'h11);
      #2;
      checks++; if (imem_rdata !== exp_b) begin errors++; $display("FAIL full_imem[%0d]: got %h exp %h", a, imem_rdata, exp_b); end
      checks++; if (dmem_rdata !== exp_b) begin errors++; $display("FAIL full_dmem[%0d]: got %h exp %h", a, dmem_rdata, exp_b); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_run_halt;
    dmem_we = 1'b1; dmem_waddr = 4'd5; dmem_wdata = 8'h3C;
    @(posedge clk); #1;
    dmem_we = 1'b0; dmem_raddr = 4'd5; #1;
    checks++; if (dmem_rdata !== 8'h3C) begin errors++; $display("FAIL run_dmem5: got %h exp 3c", dmem_rdata); end
    halt_in = 1'b1;
    @(posedge clk); #1;
    halt_in = 1'b0;
    checks++; if (run_out !== 1'b0) begin errors++; $display("FAIL halt_run: got %b exp 0", run_out); end
    checks++; if (done_out !== 1'b1) begin errors++; $display("FAIL halt_done: got %b exp 1", done_out); end
    dmem_we = 1'b1; dmem_waddr = 4'd6; dmem_wdata = 8'h00;
    @(posedge clk); #1;
    dmem_we = 1'b0; dmem_raddr = 4'd6; #1;
    checks++; if (dmem_rdata !== 8'h66) begin errors++; $display("FAIL halt_we_ignored: got %h exp 66", dmem_rdata); end
    mode_in = 2'b00;
    @(posedge clk); #1;
    checks++; if (done_out !== 1'b0) begin errors++; $display("FAIL halt_done_clear: got %b exp 0", done_out); end
  endtask

  task automatic test_stop_bit;
    shift_bits(2'b01, mk_frame(1'b1, 8'h77, 4'd2), 13);
    @(posedge clk); #1;
    imem_raddr = 4'd2;
    checks++; if (frame_err_out !== 1'b1) begin errors++; $display("FAIL stop_err: got %b exp 1", frame_err_out); end
    checks++; if (frames_rcvd !== 5'd0) begin errors++; $display("FAIL stop_frames: got %0d exp 0", frames_rcvd); end
    checks++; if (imem_rdata !== 8'h22) begin errors++; $display("FAIL stop_imem2: got %h exp 22", imem_rdata); end
    // same mode held in GAP with a clean frame on the wire must not be taken
    for (int i = 0; i < 13; i++) begin
      mosi_in = mk_frame(1'b0, 8'h99, 4'd2) >> i;
      repeat (2) @(posedge clk);
      #1;
    end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (imem_rdata !== 8'h22) begin errors++; $display("FAIL gap_imem2: got %h exp 22", imem_rdata); end
    checks++; if (frames_rcvd !== 5'd0) begin errors++; $display("FAIL gap_frames: got %0d exp 0", frames_rcvd); end
    checks++; if (checksum_out !== 8'h00) begin errors++; $display("FAIL gap_cksum_cleared: got %h exp 00", checksum_out); end
    mode_in = 2'b00;
    @(posedge clk); #1;
  endtask

  task automatic test_abort_shift;
    shift_bits(2'b10, mk_frame(1'b0, 8'hEE, 4'd7), 6);
    checks++; if (frame_err_out !== 1'b0) begin errors++; $display("FAIL abort_err_cleared: got %b exp 0", frame_err_out); end
    mode_in = 2'b00;
    @(posedge clk); #1;
    dmem_raddr = 4'd7; #1;
    checks++; if (frame_err_out !== 1'b1) begin errors++; $display("FAIL abort_err: got %b exp 1", frame_err_out); end
    checks++; if (dmem_rdata !== 8'h77) begin errors++; $display("FAIL abort_dmem7: got %h exp 77", dmem_rdata); end
    checks++; if (frames_rcvd !== 5'd0) begin errors++; $display("FAIL abort_frames: got %0d exp 0", frames_rcvd); end
  endtask

  task automatic test_abort_to_run;
    shift_bits(2'b01, mk_frame(1'b0, 8'h11, 4'd9), 3);
    mode_in = 2'b11;
    @(posedge clk); #1;
    checks++; if (run_out !== 1'b1) begin errors++; $display("FAIL a2r_run: got %b exp 1", run_out); end
    checks++; if (frame_err_out !== 1'b1) begin errors++; $display("FAIL a2r_err: got %b exp 1", frame_err_out); end
    imem_raddr = 4'd9; #1;
    checks++; if (imem_rdata !== 8'h99) begin errors++; $display("FAIL a2r_imem9: got %h exp 99", imem_rdata); end
    mode_in = 2'b00;
    @(posedge clk); #1;
    checks++; if (run_out !== 1'b0) begin errors++; $display("FAIL a2r_run_off: got %b exp 0", run_out); end
  endtask

  task automatic test_checksum;
    send_frame(2'b01, 4'd1, 8'h0F);
    send_frame(2'b10, 4'd2, 8'hF0);
    send_frame(2'b01, 4'd4, 8'h33);
    checks++; if (checksum_out !== (CK ? 8'hCC : 8'h00)) begin errors++; $display("FAIL cksum_cc: got %h", checksum_out); end
    checks++; if (frames_rcvd !== 5'd3) begin errors++; $display("FAIL cksum_frames: got %0d exp 3", frames_rcvd); end
    checks++; if (frame_err_out !== 1'b0) begin errors++; $display("FAIL cksum_err: got %b exp 0", frame_err_out); end
    imem_raddr = 4'd4; dmem_raddr = 4'd2; #1;
    checks++; if (imem_rdata !== 8'h33) begin errors++; $display("FAIL cksum_imem4: got %h exp 33", imem_rdata); end
    checks++; if (dmem_rdata !== 8'hF0) begin errors++; $display("FAIL cksum_dmem2: got %h exp f0", dmem_rdata); end
    // error raised with a non-zero count must survive the next load start
    send_frame(2'b01, 4'd5, 8'h44);
    shift_bits(2'b01, mk_frame(1'b1, 8'h12, 4'd5), 13);
    @(posedge clk); #1;
    mode_in = 2'b00;
    @(posedge clk); #1;
    send_frame(2'b10, 4'd9, 8'h5A);
    dmem_raddr = 4'd9; #1;
    checks++; if (frame_err_out !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b exp 1", frame_err_out); end
    checks++; if (frames_rcvd !== 5'd5) begin errors++; $display("FAIL sticky_frames: got %0d exp 5", frames_rcvd); end
    checks++; if (dmem_rdata !== 8'h5A) begin errors++; $display("FAIL sticky_dmem9: got %h exp 5a", dmem_rdata); end
    checks++; if (checksum_out !== (CK ? 8'hD2 : 8'h00)) begin errors++; $display("FAIL cksum_final: got %h", checksum_out); end
  endtask

  initial begin
    test_reset;
    test_single_frame;
    test_full_load;
    test_run_halt;
    test_stop_bit;
    test_abort_shift;
    test_abort_to_run;
    test_checksum;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
